// File: rtl/mbm_antilog_unit.sv
// -----------------------------------------------------------------------------
// mbm_antilog_unit
//   Antilogarithm (decode) stage of the Mitchell-based multiplier. Takes the
//   log-domain sum {characteristic, fraction} and rebuilds the approximate
//   linear product (1.f) * 2^characteristic as a 2N-bit integer, shifting the
//   mantissa left by one bit per clock.
//
//   Optional build macro: MBM_ANTILOG_ROUND_EN
//     defined   -> round half up on the last discarded fraction bit
//     undefined -> plain truncation (default)
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   in_valid        characteristic/fraction/zero are valid
//   in_ready        unit can accept a new input (IDLE only)
//   characteristic  integer part of the log sum, L+1 bits (0..2N-1)
//   fraction        fractional part of the log sum, N-1 bits
//   zero            a multiplicand was zero; product forced to 0
//   out_valid       product is valid (held until out_ready)
//   out_ready       downstream accepts the product
//   product         approximate product, 2N bits
// -----------------------------------------------------------------------------
module mbm_antilog_unit #(
    parameter int N = 8,
    parameter int L = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [L:0]       characteristic,
    input  logic [N-2:0]     fraction,
    input  logic             zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product
);

    localparam int AW = 3*N - 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [AW-1:0]   acc;
    logic [L:0]      cnt;
    logic [2*N-1:0]  next_product;

    // Integer part of the shifted mantissa; the binary point sits N-1 bits up.
    always_comb begin
        next_product = acc[AW-1:N-1];
`ifdef MBM_ANTILOG_ROUND_EN
        next_product = acc[AW-1:N-1] + {{(2*N-1){1'b0}}, acc[N-2]};
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            product   <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        // A zero operand makes one pass through SHIFT with a
                        // cleared accumulator: product 0, one-cycle latency.
                        if (zero) begin
                            acc <= '0;
                            cnt <= '0;
                        end else begin
                            acc <= {{(AW-N){1'b0}}, 1'b1, fraction};
                            cnt <= characteristic;
                        end
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc <= acc << 1;
                        cnt <= cnt - 1'b1;
                    end else begin
                        product   <= next_product;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
